// File: rtl/lu_mat_row_store_if.sv
// Host-load, lu row-read, lu row-write and control signals of the matrix row store.
// The slave modport is the store side; the master modport is the host/lu side.
interface lu_mat_row_store_if #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned WIDTH = 64
);
    localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
    localparam int unsigned AW    = $clog2(SIZE);

    logic             flush_i;
    logic [ROW_W-1:0] load_row_i;
    logic             load_valid_i;
    logic             load_ready_o;
    logic             lu_start_o;
    logic             lu_busy_i;
    logic             lu_in_ready_i;
    logic [AW-1:0]    rd_addr_i;
    logic             rd_valid_i;
    logic [ROW_W-1:0] mat_row_o;
    logic [AW-1:0]    mat_row_addr_o;
    logic             mat_row_valid_o;
    logic [ROW_W-1:0] wr_row_i;
    logic [AW-1:0]    wr_addr_i;
    logic             wr_valid_i;
    logic             wr_ready_o;
    logic             done_o;

    modport slave (
        input  flush_i, load_row_i, load_valid_i, lu_busy_i, lu_in_ready_i,
               rd_addr_i, rd_valid_i, wr_row_i, wr_addr_i, wr_valid_i,
        output load_ready_o, lu_start_o, mat_row_o, mat_row_addr_o,
               mat_row_valid_o, wr_ready_o, done_o
    );

    modport master (
        output flush_i, load_row_i, load_valid_i, lu_busy_i, lu_in_ready_i,
               rd_addr_i, rd_valid_i, wr_row_i, wr_addr_i, wr_valid_i,
        input  load_ready_o, lu_start_o, mat_row_o, mat_row_addr_o,
               mat_row_valid_o, wr_ready_o, done_o
    );
endinterface

// File: rtl/lu_mat_row_store.sv
// Row-organised matrix store feeding the lu block: loads SIZE host rows, starts lu,
// serves 1-cycle row reads, absorbs row write-backs and flags completion.
module lu_mat_row_store #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned WIDTH = 64
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    lu_mat_row_store_if.slave   bus
);
    localparam int unsigned ROW_W = SIZE * 2 * WIDTH;
    localparam int unsigned AW    = $clog2(SIZE);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_RUN
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    load_cnt_q, load_cnt_d;
    logic             seen_busy_q, seen_busy_d;
    logic [ROW_W-1:0] mem [SIZE];

    logic             load_acc, wr_acc, rd_acc;
    logic             load_ready, lu_start, wr_ready, done;
    logic [ROW_W-1:0] rd_row_q;
    logic [AW-1:0]    rd_addr_q;
    logic             rd_valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_LOAD;
            load_cnt_q  <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        seen_busy_d = seen_busy_q;
        load_ready  = 1'b0;
        lu_start    = 1'b0;
        wr_ready    = 1'b0;
        done        = 1'b0;
        load_acc    = 1'b0;
        wr_acc      = 1'b0;
        rd_acc      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_ready = 1'b1;
                load_acc   = bus.load_valid_i && !bus.flush_i;
                if (load_acc) begin
                    if (load_cnt_q == AW'(SIZE - 1)) begin
                        state_d    = ST_START;
                        load_cnt_d = '0;
                    end else begin
                        load_cnt_d = load_cnt_q + AW'(1);
                    end
                end
            end
            ST_START: begin
                lu_start    = 1'b1;
                seen_busy_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                wr_ready = 1'b1;
                wr_acc   = bus.wr_valid_i && !bus.flush_i;
                rd_acc   = bus.rd_valid_i && !bus.flush_i;
                if (bus.lu_busy_i) begin
                    seen_busy_d = 1'b1;
                end
                // Completion is only believed once lu has been seen busy, so an idle
                // lu that is merely ready right after start does not end the run.
                if (seen_busy_q && !bus.lu_busy_i && bus.lu_in_ready_i && !bus.flush_i) begin
                    done    = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
        if (bus.flush_i) begin
            state_d     = ST_LOAD;
            load_cnt_d  = '0;
            seen_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_acc) begin
            mem[load_cnt_q] <= bus.load_row_i;
        end
        if (wr_acc) begin
            mem[bus.wr_addr_i] <= bus.wr_row_i;
        end
    end

    // Write-first: a same-edge write to the row being read is forwarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_row_q   <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_addr_q <= bus.rd_addr_i;
                rd_row_q  <= (wr_acc && (bus.wr_addr_i == bus.rd_addr_i)) ? bus.wr_row_i
                                                                          : mem[bus.rd_addr_i];
            end
        end
    end

    assign bus.load_ready_o    = load_ready;
    assign bus.lu_start_o      = lu_start;
    assign bus.wr_ready_o      = wr_ready;
    assign bus.done_o          = done;
    assign bus.mat_row_valid_o = rd_valid_q;
    assign bus.mat_row_addr_o  = rd_addr_q;
    assign bus.mat_row_o       = rd_row_q;
endmodule

// File: tb/tb_lu_mat_row_store.sv
// Scoreboard bench for lu_mat_row_store: a reference matrix array predicts every row read,
// a negedge monitor compares each presented row against the expected-response queue.
module tb_lu_mat_row_store;
    localparam int unsigned SIZE  = 16;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned EW    = 2 * WIDTH;
    localparam int unsigned ROW_W = SIZE * EW;
    localparam int unsigned AW    = $clog2(SIZE);

    typedef struct {
        logic [AW-1:0]    addr;
        logic [ROW_W-1:0] row;
    } rd_exp_t;

    logic clk;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    rd_exp_t          sb [$];
    logic [ROW_W-1:0] ref_mem [SIZE];

    lu_mat_row_store_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    lu_mat_row_store #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [ROW_W-1:0] make_row(input int r);
        logic [ROW_W-1:0] row;
        real v;
        row = '0;
        for (int j = 0; j < int'(SIZE); j++) begin
            v = real'(r * int'(SIZE) + j);
            row[j*EW +: WIDTH]         = $realtobits(v);
            row[j*EW + WIDTH +: WIDTH] = $realtobits(-v);
        end
        return row;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] row;
        for (int i = 0; i < int'(ROW_W / 32); i++) begin
            row[i*32 +: 32] = $urandom;
        end
        return row;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // live=1: the store is known to be in RUN without flush, so the model follows it
    task automatic issue(input bit live, input bit rv, input logic [AW-1:0] ra,
                         input bit wv, input logic [AW-1:0] wa, input logic [ROW_W-1:0] wrow);
        rd_exp_t e;
        bus.rd_valid_i = rv;
        bus.rd_addr_i  = ra;
        bus.wr_valid_i = wv;
        bus.wr_addr_i  = wa;
        bus.wr_row_i   = wrow;
        if (live) begin
            if (wv) ref_mem[wa] = wrow;
            if (rv) begin
                e.addr = ra;
                e.row  = ref_mem[ra];
                sb.push_back(e);
            end
        end
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic load_rows(input int first, input int count, input bit pattern);
        logic [ROW_W-1:0] row;
        for (int k = 0; k < count; k++) begin
            bus.load_valid_i = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            row = pattern ? make_row(first + k) : rand_row();
            bus.load_valid_i = 1'b1;
            bus.load_row_i   = row;
            chk("load_ready_in_load", 64'(bus.load_ready_o), 64'd1);
            step();
            ref_mem[first + k] = row;
        end
        bus.load_valid_i = 1'b0;
    endtask

    task automatic expect_start();
        chk("start_pulse", 64'(bus.lu_start_o), 64'd1);
        chk("load_ready_low_start", 64'(bus.load_ready_o), 64'd0);
        step();
        chk("start_single", 64'(bus.lu_start_o), 64'd0);
        chk("wr_ready_run", 64'(bus.wr_ready_o), 64'd1);
    endtask

    task automatic read_all();
        for (int i = 0; i < int'(SIZE); i++) begin
            issue(1'b1, 1'b1, AW'(i), 1'b0, '0, '0);
            step();
            chk("b2b_valid", 64'(bus.mat_row_valid_o), 64'd1);
        end
        idle();
        step();
        chk("b2b_valid_end", 64'(bus.mat_row_valid_o), 64'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        rd_exp_t e;
        int      w;
        if (rst_ni && bus.mat_row_valid_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: got valid addr %0d expected no read at %0t",
                         bus.mat_row_addr_o, $time);
            end else begin
                e = sb.pop_front();
                if (bus.mat_row_addr_o !== e.addr || bus.mat_row_o !== e.row) begin
                    errors++;
                    w = 0;
                    for (int i = int'(ROW_W / 64) - 1; i >= 0; i--)
                        if (bus.mat_row_o[i*64 +: 64] !== e.row[i*64 +: 64]) w = i;
                    $display("FAIL read_row: got addr %0d word%0d %h expected addr %0d word%0d %h at %0t",
                             bus.mat_row_addr_o, w, bus.mat_row_o[w*64 +: 64],
                             e.addr, w, e.row[w*64 +: 64], $time);
                end
            end
        end
    end

    initial begin
        logic [ROW_W-1:0] x_row;
        logic [ROW_W-1:0] h_row;
        bit               rv, wv;

        rst_ni           = 1'b0;
        bus.flush_i      = 1'b0;
        bus.load_row_i   = '0;
        bus.load_valid_i = 1'b0;
        bus.lu_busy_i    = 1'b0;
        bus.lu_in_ready_i = 1'b0;
        idle();
        repeat (3) step();
        chk("rst_load_ready", 64'(bus.load_ready_o), 64'd1);
        chk("rst_start", 64'(bus.lu_start_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_valid", 64'(bus.mat_row_valid_o), 64'd0);
        chk("rst_wr_ready", 64'(bus.wr_ready_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // Pattern load; reads during LOAD must be ignored
        bus.rd_valid_i = 1'b1;
        bus.rd_addr_i  = AW'(2);
        load_rows(0, int'(SIZE), 1'b1);
        idle();
        expect_start();

        // lu ready before ever being busy: no completion
        bus.lu_in_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("no_done_before_busy", 64'(bus.done_o), 64'd0);
            step();
        end

        issue(1'b1, 1'b1, AW'(5), 1'b0, '0, '0);
        step();
        idle();
        chk("rd5_valid", 64'(bus.mat_row_valid_o), 64'd1);
        chk("rd5_addr", 64'(bus.mat_row_addr_o), 64'd5);
        chk("rd5_e3_real", bus.mat_row_o[3*EW +: 64], $realtobits(83.0));
        chk("rd5_e3_imag", bus.mat_row_o[3*EW + WIDTH +: 64], $realtobits(-83.0));
        step();

        read_all();

        // Same-edge write/read hazard on row 3
        x_row = rand_row();
        issue(1'b1, 1'b1, AW'(3), 1'b1, AW'(3), x_row);
        step();
        idle();
        chk("hazard_fwd_lo", bus.mat_row_o[63:0], x_row[63:0]);
        issue(1'b1, 1'b1, AW'(3), 1'b0, '0, '0);
        step();
        issue(1'b1, 1'b1, AW'(4), 1'b0, '0, '0);
        step();
        idle();
        step();

        for (int i = 0; i < 150; i++) begin
            rv = 1'($urandom_range(0, 1));
            wv = 1'($urandom_range(0, 1));
            issue(1'b1, rv, AW'($urandom_range(0, SIZE - 1)), wv,
                  AW'($urandom_range(0, SIZE - 1)), rand_row());
            step();
        end
        idle();
        step();

        // lu busy for 40 cycles with a host row held against a closed load port
        h_row = rand_row();
        bus.load_valid_i = 1'b1;
        bus.load_row_i   = h_row;
        bus.lu_busy_i    = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            chk("no_done_while_busy", 64'(bus.done_o), 64'd0);
        end
        chk("load_ready_low_run", 64'(bus.load_ready_o), 64'd0);
        bus.lu_busy_i = 1'b0;
        #1;
        chk("done_pulse", 64'(bus.done_o), 64'd1);
        step();
        chk("done_single", 64'(bus.done_o), 64'd0);
        chk("back_to_load", 64'(bus.load_ready_o), 64'd1);
        step();
        ref_mem[0] = h_row;
        bus.load_valid_i = 1'b0;

        // 7 rows total, then flush must restart the row count
        load_rows(1, 6, 1'b0);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush_load_ready", 64'(bus.load_ready_o), 64'd1);
        chk("flush_no_start", 64'(bus.lu_start_o), 64'd0);
        load_rows(0, int'(SIZE), 1'b0);
        expect_start();
        chk("no_done_after_flush", 64'(bus.done_o), 64'd0);
        read_all();

        // Flush in RUN drops the in-flight read and write
        bus.flush_i = 1'b1;
        issue(1'b0, 1'b1, AW'(2), 1'b1, AW'(2), rand_row());
        step();
        bus.flush_i = 1'b0;
        idle();
        chk("flush_run_valid", 64'(bus.mat_row_valid_o), 64'd0);
        chk("flush_run_wr_ready", 64'(bus.wr_ready_o), 64'd0);
        chk("flush_run_done", 64'(bus.done_o), 64'd0);
        chk("flush_run_load_ready", 64'(bus.load_ready_o), 64'd1);
        step();

        // Reset while a read is in flight
        load_rows(0, int'(SIZE), 1'b1);
        expect_start();
        issue(1'b1, 1'b1, AW'(7), 1'b0, '0, '0);
        step();
        issue(1'b0, 1'b0, '0, 1'b1, AW'(1), rand_row());
        #1;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(bus.mat_row_valid_o), 64'd0);
        chk("arst_start", 64'(bus.lu_start_o), 64'd0);
        chk("arst_done", 64'(bus.done_o), 64'd0);
        sb.delete();
        step();
        rst_ni = 1'b1;
        step();
        chk("arst_load_ready", 64'(bus.load_ready_o), 64'd1);
        chk("arst_wr_ready", 64'(bus.wr_ready_o), 64'd0);
        idle();
        step();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
